cp_dmem_bus_arbiter: RTL
========================

Name: cp_dmem_bus_arbiter

Overview:
Two-requester arbiter for the bus port (port A) of the control-processor data memory. Requester 0 is the host/bus interface; requester 1 is the DMA engine. It grants one access per cycle round-robin, supports locked bursts with a watchdog, and routes 1-cycle-latency read data back to the issuing requester. It sits between the system interconnect and the dmem port-A pins; core port B is untouched.

Parameters:
ADDR_WIDTH, `DEF_CP_D_MEM_ADDR_WIDTH, byte address width of port A
DATA_WIDTH, `DEF_CP_DATA_WIDTH, data word width
LOCK_MAX_CYCLES, 64, max cycles a lock may be held before forced release (>=2)

Ports:
iClk  in  1  system clock, posedge
iReset_n  in  1  asynchronous active-low reset
iReq0_Valid / iReq1_Valid  in  1  access request
iReq0_Address / iReq1_Address  in  ADDR_WIDTH  byte address
iReq0_Write_Data / iReq1_Write_Data  in  DATA_WIDTH  write data
iReq0_Write_Enable / iReq1_Write_Enable  in  1  1=write, 0=read
iReq0_Lock / iReq1_Lock  in  1  hold grant after this transfer
oReq0_Ready / oReq1_Ready  out  1  grant; transfer when Valid&Ready
oReq0_Read_Data / oReq1_Read_Data  out  DATA_WIDTH  read return data
oReq0_Read_Valid / oReq1_Read_Valid  out  1  read data valid, one cycle
oBus_Valid  out  1  to dmem iBus_Valid
oBus_Address  out  ADDR_WIDTH  to dmem iBus_Address
oBus_Write_Data  out  DATA_WIDTH  to dmem iBus_Write_Data
oBus_Write_Enable  out  1  to dmem iBus_Write_Enable
iBus_Read_Data  in  DATA_WIDTH  from dmem oBus_Read_Data

Behaviour:
- Reset (async assert, sync deassert by caller): state=OPEN, rr pointer=0 (req0 first priority), lock counter=0, both Read_Valid=0, stats=0. Ready/oBus_* combinational; with no Valid, all 0.
- OPEN: if exactly one Valid -> grant it. Both Valid -> grant the one rr pointer names; on accepted transfer pointer moves to the other requester. No Valid -> pointer unchanged.
- Ready depends on Valids and state only; Ready may assert only with that requester's Valid.
- oBus_* = muxed fields of granted requester; oBus_Valid = granted Valid; all 0 when no grant.
- Accepted transfer with Lock=1 -> LOCKED(owner), counter=0. In LOCKED only the owner is granted; the other is stalled even if owner idle. Counter increments every LOCKED cycle.
- LOCKED exit: owner transfer with Lock=0 -> OPEN, pointer to non-owner. Counter reaching LOCKED_MAX_CYCLES-1 -> forced OPEN, pointer to non-owner; a transfer in that same cycle is still accepted, its Lock ignored.
- Read return: accepted read at edge t sets ReqN_Read_Valid for exactly the following cycle; ReqN_Read_Data = iBus_Read_Data (unregistered), both Read_Data outputs driven from it, gated by nothing. Back-to-back reads give back-to-back Read_Valid. Writes produce no return.
- Reset mid-operation: pending Read_Valid dropped, LOCKED cleared, no stale return after release.
- Address passes through unmodified (dmem selects word bits).

Optional Feature:
CP_DMEM_ARB_STATS_EN: defined -> extra outputs oStat_Grant0, oStat_Grant1, oStat_Conflict (16-bit each, saturating at 16'hFFFF) counting accepted transfers per requester and cycles with both Valid where one was stalled; cleared by reset only. Undefined -> ports and counters absent, no other change.

Decomposition:
- Shared package/include def-cp.v: state encoding (CP_ARB_OPEN=1'b0, CP_ARB_LOCKED=1'b1), stats counter width constant 16.
- One natural sub-module: cp_arb_rr2 (2-way round-robin grant with pointer update); rest inline.

Test Plan:
- Single req0 write addr 0x10 data 0xDEADBEEF, then read 0x10 -> Ready0 same cycle; Read_Valid0 next cycle with 0xDEADBEEF; Read_Valid1 stays 0.
- Both Valid continuous reads for 6 cycles from reset -> grants 0,1,0,1,0,1; Read_Valid alternates one cycle later.
- req1 locked burst of 4 writes (Lock=1,1,1,0) with req0 Valid throughout -> req0 Ready=0 for 4 transfers, req0 granted next cycle.
- req0 Lock=1 then idles, LOCK_MAX_CYCLES=8 -> req1 stalled 8 cycles, granted on 9th; pointer favours req1.
- iReset_n pulsed low the cycle after a read accept -> Read_Valid0 0 immediately, state OPEN, pointer 0.
- With CP_DMEM_ARB_STATS_EN, 10 conflicting cycles -> oStat_Conflict=10, Grant0=5, Grant1=5; preload near 0xFFFF saturates.

Source files
------------

// File: rtl/cp_dmem_bus_arbiter_pkg.sv
`default_nettype none
//==============================================================================
// Module   : cp_dmem_bus_arbiter_pkg
// Purpose  : Shared definitions for the data-memory port-A arbiter slice:
//            arbitration state encoding, statistics counter width and type,
//            and a saturating-increment helper.
//            Supplies fallback values for DEF_CP_D_MEM_ADDR_WIDTH and
//            DEF_CP_DATA_WIDTH when the surrounding build does not define them.
// Ports    : none (package)
// Revision : 1.0  initial release
//==============================================================================

`ifndef DEF_CP_D_MEM_ADDR_WIDTH
`define DEF_CP_D_MEM_ADDR_WIDTH 12
`endif

`ifndef DEF_CP_DATA_WIDTH
`define DEF_CP_DATA_WIDTH 32
`endif

package cp_dmem_bus_arbiter_pkg;

  // Arbitration state encoding
  localparam logic [0:0] CP_ARB_OPEN   = 1'b0;
  localparam logic [0:0] CP_ARB_LOCKED = 1'b1;

  // Statistics counters
  localparam int CP_ARB_STAT_WIDTH = 16;

  typedef logic [CP_ARB_STAT_WIDTH-1:0] cpArbStat_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic cpArbStat_t cpArbSatInc(input cpArbStat_t value);
    cpArbStat_t result;
    if (value == '1) begin
      result = value;
    end else begin
      result = value + cpArbStat_t'(1);
    end
    return result;
  endfunction

endpackage : cp_dmem_bus_arbiter_pkg

`default_nettype wire

// File: rtl/cp_dmem_bus_arbiter_if.sv
`default_nettype none
//==============================================================================
// Module   : cp_dmem_bus_arbiter_if
// Purpose  : Bundle of the two requester handshakes and the dmem port-A pins.
//            slave  modport : arbiter view (takes requests, drives the bus)
//            master modport : environment view (requesters + dmem)
// Ports    : iReqN_*  request fields from requester N (N = 0 host, 1 DMA)
//            oReqN_*  grant and read-return to requester N
//            oBus_*   access presented to dmem port A
//            iBus_Read_Data  1-cycle-latency read data from dmem
// Revision : 1.0  initial release
//==============================================================================
interface cp_dmem_bus_arbiter_if #(
  parameter int ADDR_WIDTH = `DEF_CP_D_MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = `DEF_CP_DATA_WIDTH
);

  logic                  iReq0_Valid;
  logic [ADDR_WIDTH-1:0] iReq0_Address;
  logic [DATA_WIDTH-1:0] iReq0_Write_Data;
  logic                  iReq0_Write_Enable;
  logic                  iReq0_Lock;
  logic                  oReq0_Ready;
  logic [DATA_WIDTH-1:0] oReq0_Read_Data;
  logic                  oReq0_Read_Valid;

  logic                  iReq1_Valid;
  logic [ADDR_WIDTH-1:0] iReq1_Address;
  logic [DATA_WIDTH-1:0] iReq1_Write_Data;
  logic                  iReq1_Write_Enable;
  logic                  iReq1_Lock;
  logic                  oReq1_Ready;
  logic [DATA_WIDTH-1:0] oReq1_Read_Data;
  logic                  oReq1_Read_Valid;

  logic                  oBus_Valid;
  logic [ADDR_WIDTH-1:0] oBus_Address;
  logic [DATA_WIDTH-1:0] oBus_Write_Data;
  logic                  oBus_Write_Enable;
  logic [DATA_WIDTH-1:0] iBus_Read_Data;

  modport slave (
    input  iReq0_Valid, iReq0_Address, iReq0_Write_Data, iReq0_Write_Enable, iReq0_Lock,
    output oReq0_Ready, oReq0_Read_Data, oReq0_Read_Valid,
    input  iReq1_Valid, iReq1_Address, iReq1_Write_Data, iReq1_Write_Enable, iReq1_Lock,
    output oReq1_Ready, oReq1_Read_Data, oReq1_Read_Valid,
    output oBus_Valid, oBus_Address, oBus_Write_Data, oBus_Write_Enable,
    input  iBus_Read_Data
  );

  modport master (
    output iReq0_Valid, iReq0_Address, iReq0_Write_Data, iReq0_Write_Enable, iReq0_Lock,
    input  oReq0_Ready, oReq0_Read_Data, oReq0_Read_Valid,
    output iReq1_Valid, iReq1_Address, iReq1_Write_Data, iReq1_Write_Enable, iReq1_Lock,
    input  oReq1_Ready, oReq1_Read_Data, oReq1_Read_Valid,
    input  oBus_Valid, oBus_Address, oBus_Write_Data, oBus_Write_Enable,
    output iBus_Read_Data
  );

endinterface : cp_dmem_bus_arbiter_if

`default_nettype wire

// File: rtl/cp_dmem_bus_arbiter_rr2.sv
`default_nettype none
//==============================================================================
// Module   : cp_dmem_bus_arbiter_rr2
// Purpose  : Two-way round-robin grant. Combinational grant from the two
//            (already lock-masked) requests and the priority pointer; the
//            pointer is held here and either advances past the granted
//            requester or is loaded explicitly by the caller.
// Ports    : iClk, iReset_n      clock, async active-low reset
//            iReq0, iReq1        requests eligible for a grant this cycle
//            iAdvance            a grant was accepted; point at the other side
//            iLoad, iLoadPtr     force the pointer (takes priority)
//            oGrant0, oGrant1    one-hot-or-zero grant
// Revision : 1.0  initial release
//==============================================================================
module cp_dmem_bus_arbiter_rr2 (
  input  logic iClk,
  input  logic iReset_n,
  input  logic iReq0,
  input  logic iReq1,
  input  logic iAdvance,
  input  logic iLoad,
  input  logic iLoadPtr,
  output logic oGrant0,
  output logic oGrant1
);

  // Pointer value names the requester that wins a tie
  logic r_ptr;

  assign oGrant0 = iReq0 & (~iReq1 | ~r_ptr);
  assign oGrant1 = iReq1 & (~iReq0 |  r_ptr);

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_ptr <= 1'b0;
    end else if (iLoad) begin
      r_ptr <= iLoadPtr;
    end else if (iAdvance) begin
      // Granting req0 hands priority to req1 and vice versa
      r_ptr <= oGrant0;
    end
  end

endmodule : cp_dmem_bus_arbiter_rr2

`default_nettype wire

// File: rtl/cp_dmem_bus_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : cp_dmem_bus_arbiter
// Purpose  : Arbiter for dmem port A between the host interface (req0) and
//            the DMA engine (req1). One access per cycle, round-robin on
//            contention, locked bursts with a forced-release watchdog, and
//            1-cycle-latency read data routed back to the issuing requester.
// Ports    : iClk      system clock, posedge
//            iReset_n  asynchronous active-low reset
//            bus       cp_dmem_bus_arbiter_if.slave (requesters + dmem pins)
//            oStat_Grant0/oStat_Grant1/oStat_Conflict  saturating counters,
//                      present only when CP_DMEM_ARB_STATS_EN is defined
// Options  : CP_DMEM_ARB_STATS_EN  adds the statistics counters and ports
// Revision : 1.0  initial release
//==============================================================================
module cp_dmem_bus_arbiter
  import cp_dmem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH      = `DEF_CP_D_MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH      = `DEF_CP_DATA_WIDTH,
  parameter int LOCK_MAX_CYCLES = 64
) (
  input  logic                         iClk,
  input  logic                         iReset_n,
  cp_dmem_bus_arbiter_if.slave         bus
`ifdef CP_DMEM_ARB_STATS_EN
  ,
  output logic [CP_ARB_STAT_WIDTH-1:0] oStat_Grant0,
  output logic [CP_ARB_STAT_WIDTH-1:0] oStat_Grant1,
  output logic [CP_ARB_STAT_WIDTH-1:0] oStat_Conflict
`endif
);

  localparam int                 c_CNT_W    = (LOCK_MAX_CYCLES > 2) ? $clog2(LOCK_MAX_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(LOCK_MAX_CYCLES - 1);

  logic [0:0]         r_state;
  logic               r_owner;
  logic [c_CNT_W-1:0] r_lockCnt;
  logic               r_readValid0;
  logic               r_readValid1;

  logic                  w_locked;
  logic                  w_req0;
  logic                  w_req1;
  logic                  w_grant0;
  logic                  w_grant1;
  logic                  w_accept;
  logic                  w_grantLock;
  logic                  w_lockExit;
  logic [ADDR_WIDTH-1:0] w_busAddress;
  logic [DATA_WIDTH-1:0] w_busWriteData;
  logic                  w_busWriteEnable;

  assign w_locked = (r_state == CP_ARB_LOCKED);

  // While locked the non-owner is masked out, even if the owner is idle
  assign w_req0 = bus.iReq0_Valid & (~w_locked | ~r_owner);
  assign w_req1 = bus.iReq1_Valid & (~w_locked |  r_owner);

  cp_dmem_bus_arbiter_rr2 u_rr2 (
    .iClk     (iClk),
    .iReset_n (iReset_n),
    .iReq0    (w_req0),
    .iReq1    (w_req1),
    .iAdvance (~w_locked & w_accept),
    .iLoad    (w_lockExit),
    .iLoadPtr (~r_owner),
    .oGrant0  (w_grant0),
    .oGrant1  (w_grant1)
  );

  // A grant is only ever issued alongside Valid, so a grant is a transfer
  assign w_accept    = w_grant0 | w_grant1;
  assign w_grantLock = (w_grant0 & bus.iReq0_Lock) | (w_grant1 & bus.iReq1_Lock);

  // Leave LOCKED on the watchdog limit or on an owner transfer without Lock
  assign w_lockExit = w_locked & ((r_lockCnt == c_CNT_LAST) | (w_accept & ~w_grantLock));

  assign w_busAddress     = w_grant1 ? bus.iReq1_Address      : (w_grant0 ? bus.iReq0_Address      : '0);
  assign w_busWriteData   = w_grant1 ? bus.iReq1_Write_Data   : (w_grant0 ? bus.iReq0_Write_Data   : '0);
  assign w_busWriteEnable = (w_grant1 & bus.iReq1_Write_Enable) | (w_grant0 & bus.iReq0_Write_Enable);

  assign bus.oReq0_Ready       = w_grant0;
  assign bus.oReq1_Ready       = w_grant1;
  assign bus.oBus_Valid        = w_accept;
  assign bus.oBus_Address      = w_busAddress;
  assign bus.oBus_Write_Data   = w_busWriteData;
  assign bus.oBus_Write_Enable = w_busWriteEnable;

  // dmem has one cycle of read latency, so the return data is fanned out
  // unregistered and only the valid strobes carry ownership
  assign bus.oReq0_Read_Data  = bus.iBus_Read_Data;
  assign bus.oReq1_Read_Data  = bus.iBus_Read_Data;
  assign bus.oReq0_Read_Valid = r_readValid0;
  assign bus.oReq1_Read_Valid = r_readValid1;

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_state   <= CP_ARB_OPEN;
      r_owner   <= 1'b0;
      r_lockCnt <= '0;
    end else if (!w_locked) begin
      if (w_accept && w_grantLock) begin
        r_state   <= CP_ARB_LOCKED;
        r_owner   <= w_grant1;
        r_lockCnt <= '0;
      end
    end else if (w_lockExit) begin
      r_state   <= CP_ARB_OPEN;
      r_lockCnt <= '0;
    end else begin
      r_lockCnt <= r_lockCnt + c_CNT_W'(1);
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_readValid0 <= 1'b0;
      r_readValid1 <= 1'b0;
    end else begin
      r_readValid0 <= w_grant0 & ~bus.iReq0_Write_Enable;
      r_readValid1 <= w_grant1 & ~bus.iReq1_Write_Enable;
    end
  end

`ifdef CP_DMEM_ARB_STATS_EN
  cpArbStat_t r_statGrant0;
  cpArbStat_t r_statGrant1;
  cpArbStat_t r_statConflict;

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_statGrant0   <= '0;
      r_statGrant1   <= '0;
      r_statConflict <= '0;
    end else begin
      if (w_grant0) begin
        r_statGrant0 <= cpArbSatInc(r_statGrant0);
      end
      if (w_grant1) begin
        r_statGrant1 <= cpArbSatInc(r_statGrant1);
      end
      // Only one access per cycle, so both Valid always stalls one side
      if (bus.iReq0_Valid && bus.iReq1_Valid) begin
        r_statConflict <= cpArbSatInc(r_statConflict);
      end
    end
  end

  assign oStat_Grant0   = r_statGrant0;
  assign oStat_Grant1   = r_statGrant1;
  assign oStat_Conflict = r_statConflict;
`endif

endmodule : cp_dmem_bus_arbiter

`default_nettype wire
